// File: rtl/sap_mem_pkg.sv
// Shared definitions for the SAP 16x8 RAM access path.
// Holds the RAM geometry, the write-sequence state encoding and the width of
// the write-strobe pulse counter. Imported by mem_write_sequencer and
// ram_access_ctrl.
package sap_mem_pkg;

    localparam int unsigned RAM_ADDR_W = 4;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned MEM_DEPTH  = 1 << RAM_ADDR_W;

    // Enough to count a strobe of 1..4 cycles (stored as length-1).
    localparam int unsigned WE_CNT_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWrite,
        StHold,
        StVerify
    } seq_state_e;

endpackage

// File: rtl/mem_write_sequencer.sv
// Write-timing engine for the F189 RAM.
// A start pulse in idle captures address and data, then walks
// SETUP (1) -> WRITE (WE_PULSE_CYCLES, strobe low) -> HOLD (1)
// -> VERIFY (1, only with RAM_VERIFY_EN) -> idle.
// Address and data stay stable from SETUP through the end of the sequence.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        begin a write (honoured only in idle)
//   addr_i/data_i  write target and value, captured with start_i
//   busy_o         sequence in progress (any non-idle state)
//   hold_o         sequence is in HOLD (one cycle)
//   verify_o       sequence is in VERIFY (one cycle)
//   addr_o/data_o  captured address and data
//   we_n_o         registered active-low write strobe
// Optional: RAM_VERIFY_EN adds the VERIFY state.
module mem_write_sequencer
    import sap_mem_pkg::*;
#(
    parameter int unsigned ADDR_W          = RAM_ADDR_W,
    parameter int unsigned DATA_W          = RAM_DATA_W,
    parameter int unsigned WE_PULSE_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              hold_o,
    output logic              verify_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              we_n_o
);

    localparam logic [WE_CNT_W-1:0] LastCnt = WE_CNT_W'(WE_PULSE_CYCLES - 1);

    seq_state_e          state_q, state_d;
    logic [WE_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                we_n_q, we_n_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSetup;
                    addr_d  = addr_i;
                    data_d  = data_i;
                end
            end
            StSetup: begin
                state_d = StWrite;
                cnt_d   = '0;
            end
            StWrite: begin
                if (cnt_q == LastCnt) begin
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHold: begin
`ifdef RAM_VERIFY_EN
                state_d = StVerify;
`else
                state_d = StIdle;
`endif
            end
            StVerify: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Strobe is registered from the next state so it is glitch-free.
        we_n_d = (state_d != StWrite);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_n_q  <= we_n_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign hold_o   = (state_q == StHold);
    assign verify_o = (state_q == StVerify);
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign we_n_o   = we_n_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// RAM access controller for the SAP 16x8 F189 RAM.
// Owns the MAR and the loader pointer, arbitrates between the CPU control
// word (prog_mode=0) and the byte-stream loader (prog_mode=1), and drives
// the RAM through a shared mem_write_sequencer. Mode is only sampled idle.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   prog_mode                     1 = loader owns RAM, 0 = CPU owns RAM
//   cpu_bus, cpu_mar_load,
//   cpu_ram_in, cpu_ram_out       CPU control word
//   cpu_stall                     write sequence in progress
//   ld_start, ld_valid, ld_data   loader controls and byte stream
//   ld_ready, ld_done             loader handshake and completion
//   mem_address, mem_data,
//   mem_write_enable_n,
//   mem_bus_enable_n              RAM side
//   mem_rdata                     RAM read data (readback check only)
//   verify_err                    sticky readback mismatch
// Optional: define RAM_VERIFY_EN to read back every write and flag mismatches.
module ram_access_ctrl
    import sap_mem_pkg::*;
#(
    parameter int unsigned ADDR_W          = RAM_ADDR_W,
    parameter int unsigned DATA_W          = RAM_DATA_W,
    parameter int unsigned WE_PULSE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prog_mode,
    input  logic [DATA_W-1:0] cpu_bus,
    input  logic              cpu_mar_load,
    input  logic              cpu_ram_in,
    input  logic              cpu_ram_out,
    output logic              cpu_stall,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_enable_n,
    output logic              mem_bus_enable_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              verify_err
);

    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic              ld_done_q, ld_done_d;
    logic              ld_owner_q, ld_owner_d;  // in-flight write came from loader
    logic              ld_pend_q, ld_pend_d;    // ld_start seen mid-sequence

    logic              seq_busy, seq_hold, seq_verify, seq_we_n;
    logic [ADDR_W-1:0] seq_addr;
    logic [DATA_W-1:0] seq_data;

    logic idle, cpu_sel, ld_sel, cpu_wr, ld_wr, seq_start, apply_start;

    assign idle        = !seq_busy;
    assign cpu_sel     = idle && !prog_mode;
    assign ld_sel      = idle && prog_mode;
    assign apply_start = idle && (ld_start || ld_pend_q);
    // A restart about to clear the pointer must not race an accepted byte.
    assign ld_ready    = ld_sel && !ld_done_q && !ld_start && !ld_pend_q;
    assign cpu_wr      = cpu_sel && cpu_ram_in;
    assign ld_wr       = ld_valid && ld_ready;
    assign seq_start   = cpu_wr || ld_wr;

    mem_write_sequencer #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .WE_PULSE_CYCLES (WE_PULSE_CYCLES)
    ) u_seq (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .start_i  (seq_start),
        .addr_i   (ld_wr ? ld_ptr_q : mar_q),
        .data_i   (ld_wr ? ld_data : cpu_bus),
        .busy_o   (seq_busy),
        .hold_o   (seq_hold),
        .verify_o (seq_verify),
        .addr_o   (seq_addr),
        .data_o   (seq_data),
        .we_n_o   (seq_we_n)
    );

    always_comb begin
        mar_d      = mar_q;
        ld_ptr_d   = ld_ptr_q;
        ld_done_d  = ld_done_q;
        ld_owner_d = ld_owner_q;
        ld_pend_d  = ld_pend_q;

        // The write (if any) has already captured the old MAR this cycle.
        if (cpu_sel && cpu_mar_load) begin
            mar_d = cpu_bus[ADDR_W-1:0];
        end
        if (seq_start) begin
            ld_owner_d = ld_wr;
        end
        if (seq_busy && ld_start) begin
            ld_pend_d = 1'b1;
        end else if (apply_start) begin
            ld_pend_d = 1'b0;
        end

        if (apply_start) begin
            ld_ptr_d  = '0;
            ld_done_d = 1'b0;
        end else if (seq_hold && ld_owner_q) begin
            if (ld_ptr_q == {ADDR_W{1'b1}}) begin
                ld_ptr_d  = '0;
                ld_done_d = 1'b1;
            end else begin
                ld_ptr_d = ld_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mar_q      <= '0;
            ld_ptr_q   <= '0;
            ld_done_q  <= 1'b0;
            ld_owner_q <= 1'b0;
            ld_pend_q  <= 1'b0;
        end else begin
            mar_q      <= mar_d;
            ld_ptr_q   <= ld_ptr_d;
            ld_done_q  <= ld_done_d;
            ld_owner_q <= ld_owner_d;
            ld_pend_q  <= ld_pend_d;
        end
    end

`ifdef RAM_VERIFY_EN
    logic verify_err_q, verify_err_d;

    always_comb begin
        verify_err_d = verify_err_q;
        if (apply_start) begin
            verify_err_d = 1'b0;
        end else if (seq_verify && (mem_rdata != seq_data)) begin
            verify_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            verify_err_q <= 1'b0;
        end else begin
            verify_err_q <= verify_err_d;
        end
    end

    assign verify_err = verify_err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
    assign verify_err   = 1'b0;
`endif

    assign cpu_stall          = seq_busy;
    assign ld_done            = ld_done_q;
    assign mem_address        = seq_busy ? seq_addr : (prog_mode ? ld_ptr_q : mar_q);
    assign mem_data           = seq_data;
    assign mem_write_enable_n = seq_we_n;
    // Gated by reset_n so the output enable drops the moment reset asserts.
    assign mem_bus_enable_n   = !(reset_n && ((cpu_sel && cpu_ram_out) || seq_verify));

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: a behavioural F189 RAM plus a
// transaction-level reference model (expected RAM image, MAR, loader pointer).
module tb_ram_access_ctrl;

    localparam int unsigned WE_P = 1;
`ifdef RAM_VERIFY_EN
    localparam int unsigned VER = 1;
`else
    localparam int unsigned VER = 0;
`endif
    localparam int unsigned BUSY = 2 + WE_P + VER;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       prog_mode;
    logic [7:0] cpu_bus;
    logic       cpu_mar_load, cpu_ram_in, cpu_ram_out;
    logic       cpu_stall;
    logic       ld_start, ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready, ld_done;
    logic [3:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_write_enable_n, mem_bus_enable_n;
    logic [7:0] mem_rdata;
    logic       verify_err;

    // Behavioural RAM
    logic [7:0] ram [16];
    logic       ram_clr;
    logic       rd_force0;

    // Reference model state
    logic [7:0] exp_ram [16];
    logic [3:0] mar_exp;
    logic [3:0] ptr_exp;
    logic       done_exp;

    int n_checks = 0;
    int n_fail   = 0;

    ram_access_ctrl u_dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .prog_mode          (prog_mode),
        .cpu_bus            (cpu_bus),
        .cpu_mar_load       (cpu_mar_load),
        .cpu_ram_in         (cpu_ram_in),
        .cpu_ram_out        (cpu_ram_out),
        .cpu_stall          (cpu_stall),
        .ld_start           (ld_start),
        .ld_valid           (ld_valid),
        .ld_data            (ld_data),
        .ld_ready           (ld_ready),
        .ld_done            (ld_done),
        .mem_address        (mem_address),
        .mem_data           (mem_data),
        .mem_write_enable_n (mem_write_enable_n),
        .mem_bus_enable_n   (mem_bus_enable_n),
        .mem_rdata          (mem_rdata),
        .verify_err         (verify_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
        end else if (!mem_write_enable_n) begin
            ram[mem_address] <= mem_data;
        end
    end

    assign mem_rdata = rd_force0 ? 8'h00 : ram[mem_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
        mar_exp  = '0;
        ptr_exp  = '0;
        done_exp = 1'b0;
    endtask

    task automatic clear_ram();
        @(negedge clk);
        #1 ram_clr = 1'b1;
        @(negedge clk);
        #1 ram_clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        #1;
        while (cpu_stall && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout", cpu_stall, 0);
    endtask

    // Observe one write sequence starting the cycle after a request was driven.
    task automatic run_seq(input logic [3:0] ea, input logic [7:0] ed);
        logic [3:0] a1;
        logic [7:0] d1;
        int first_low = 0, low_cnt = 0, busy_cnt = 0, be_low = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a1 = mem_address;
                d1 = mem_data;
                cpu_ram_in   = 1'b0;
                cpu_mar_load = 1'b0;
                ld_valid     = 1'b0;
                cpu_ram_out  = 1'b1;  // enable must stay off during the write
            end
            #1;
            if (cpu_stall) busy_cnt++;
            if (cpu_stall && !mem_bus_enable_n) be_low++;
            if (!mem_write_enable_n) begin
                low_cnt++;
                if (first_low == 0) first_low = k;
            end
        end
        cpu_ram_out = 1'b0;
        check("seq_addr", a1, ea);
        check("seq_data", d1, ed);
        check("we_first", first_low, 2);
        check("we_len", low_cnt, WE_P);
        check("stall_len", busy_cnt, BUSY);
        check("be_in_write", be_low, VER);
    endtask

    task automatic cpu_op(input bit ld, input bit wr, input logic [7:0] bus);
        @(negedge clk);
        cpu_bus      = bus;
        cpu_mar_load = ld;
        cpu_ram_in   = wr;
        if (wr) begin
            run_seq(mar_exp, bus);
            exp_ram[mar_exp] = bus;
        end else begin
            @(negedge clk);
            cpu_mar_load = 1'b0;
        end
        if (ld) mar_exp = bus[3:0];
        #1 check("mar", mem_address, mar_exp);
    endtask

    task automatic cpu_read();
        @(negedge clk);
        cpu_ram_out = 1'b1;
        #1;
        check("rd_be", mem_bus_enable_n, 0);
        check("rd_addr", mem_address, mar_exp);
        check("rd_data", mem_rdata, exp_ram[mar_exp]);
        cpu_ram_out = 1'b0;
    endtask

    task automatic ld_start_pulse();
        @(negedge clk);
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ptr_exp  = '0;
        done_exp = 1'b0;
    endtask

    // Feed n bytes; ld_valid is left as the last cycle drove it.
    task automatic load_bytes(input int n, input bit gaps, input bit inc);
        int acc = 0, cyc = 0;
        logic [7:0] d;
        d = inc ? 8'h10 + 8'(ptr_exp) : 8'($urandom);
        while (acc < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            ld_data  = d;
            ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (ld_valid && ld_ready) begin
                exp_ram[ptr_exp] = d;
                if (ptr_exp == 4'hF) begin
                    ptr_exp  = '0;
                    done_exp = 1'b1;
                end else begin
                    ptr_exp = ptr_exp + 1'b1;
                end
                acc++;
                d = inc ? 8'h10 + 8'(ptr_exp) : 8'($urandom);
            end
        end
        check("ld_accepted", acc, n);
    endtask

    initial begin
        int k, rdy_k, we_cnt, rdy_cnt;
        reset_n      = 1'b0;
        prog_mode    = 1'b0;
        cpu_bus      = '0;
        cpu_mar_load = 1'b0;
        cpu_ram_in   = 1'b0;
        cpu_ram_out  = 1'b0;
        ld_start     = 1'b0;
        ld_valid     = 1'b0;
        ld_data      = '0;
        ram_clr      = 1'b1;
        rd_force0    = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;

        // Reset state
        #1;
        check("rst_we", mem_write_enable_n, 1);
        check("rst_be", mem_bus_enable_n, 1);
        check("rst_stall", cpu_stall, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_done", ld_done, 0);
        check("rst_verr", verify_err, 0);
        check("rst_data", mem_data, 0);
        check("rst_addr", mem_address, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset in the middle of a strobe
        cpu_op(1, 0, 8'h07);
        @(negedge clk);
        cpu_bus    = 8'hEE;
        cpu_ram_in = 1'b1;
        @(negedge clk);
        cpu_ram_in = 1'b0;
        @(negedge clk);
        #1 check("mid_we_low", mem_write_enable_n, 0);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_we", mem_write_enable_n, 1);
        check("mid_rst_be", mem_bus_enable_n, 1);
        check("mid_rst_stall", cpu_stall, 0);
        check("mid_rst_mar", mem_address, 0);
        check("mid_rst_done", ld_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        we_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            #1 if (!mem_write_enable_n) we_cnt++;
        end
        check("no_retry", we_cnt, 0);
        model_clear();
        clear_ram();

        // Directed CPU write and readback
        cpu_op(1, 0, 8'h05);
        cpu_op(0, 1, 8'hA7);
        cpu_read();

        // Simultaneous MAR load and write
        cpu_op(1, 0, 8'h03);
        cpu_op(1, 1, 8'h0C);
        cpu_op(1, 0, 8'h03);
        cpu_read();

        // Random CPU traffic
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: cpu_op(1, 0, 8'($urandom));
                1: cpu_op(0, 1, 8'($urandom));
                2: cpu_op(1, 1, 8'($urandom));
                default: cpu_read();
            endcase
        end

        // Full loader program with ld_valid held
        @(negedge clk);
        prog_mode = 1'b1;
        ld_start_pulse();
        load_bytes(16, 0, 1);
        wait_idle();
        check("full_done", ld_done, done_exp);
        check("full_ready", ld_ready, 0);
        check("full_ptr", mem_address, ptr_exp);
        check("full_verr", verify_err, 0);
        we_cnt  = 0;
        rdy_cnt = 0;
        ld_data = 8'h20;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (!mem_write_enable_n) we_cnt++;
            if (ld_ready) rdy_cnt++;
        end
        check("byte17_we", we_cnt, 0);
        check("byte17_ready", rdy_cnt, 0);
        ld_valid = 1'b0;
        for (int i = 0; i < 16; i++) check("full_ram", ram[i], exp_ram[i]);

        // Restart allows rewriting address 0
        ld_start_pulse();
        #1;
        check("restart_ready", ld_ready, 1);
        check("restart_done", ld_done, 0);
        load_bytes(1, 0, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        wait_idle();
        check("restart_ram0", ram[0], exp_ram[0]);

        // Random loader bytes with gaps, then ld_start mid-sequence
        load_bytes(3, 1, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        wait_idle();
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        #1 check("pend_ready", ld_ready, 1);
        exp_ram[ptr_exp] = 8'h77;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        ptr_exp  = '0;
        done_exp = 1'b0;
        wait_idle();
        @(negedge clk);
        #1;
        check("pend_ptr", mem_address, ptr_exp);
        check("pend_ready_after", ld_ready, 1);

        // Mode switch during a CPU write
        @(negedge clk);
        prog_mode  = 1'b0;
        cpu_bus    = 8'h3C;
        cpu_ram_in = 1'b1;
        @(negedge clk);
        cpu_ram_in = 1'b0;
        exp_ram[mar_exp] = 8'h3C;
        @(negedge clk);
        #1 check("ms_in_write", mem_write_enable_n, 0);
        prog_mode = 1'b1;
        ld_valid  = 1'b1;
        ld_data   = 8'h99;
        rdy_k = 0;
        k     = 0;
        while (rdy_k == 0 && k < 10) begin
            @(negedge clk);
            k++;
            #1 if (ld_ready) rdy_k = k;
        end
        check("ms_ready_cycle", rdy_k, 2 + VER);
        exp_ram[ptr_exp] = 8'h99;
        ptr_exp = ptr_exp + 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        wait_idle();
        check("ms_ptr", mem_address, ptr_exp);

        // Readback mismatch: RAM output forced to 0 while writing 0x55
        ld_start_pulse();
        rd_force0 = 1'b1;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        #1 check("vf_ready", ld_ready, 1);
        exp_ram[ptr_exp] = 8'h55;
        ptr_exp = ptr_exp + 1'b1;
        @(negedge clk);
        ld_valid = 1'b0;
        wait_idle();
        rd_force0 = 1'b0;
        check("vf_err", verify_err, VER);
        repeat (5) @(negedge clk);
        #1 check("vf_sticky", verify_err, VER);
        ld_start_pulse();
        #1 check("vf_cleared", verify_err, 0);

        // Final image comparison
        for (int i = 0; i < 16; i++) check("final_ram", ram[i], exp_ram[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
